// File: rtl/enc_link_arbiter.sv
// -----------------------------------------------------------------------------
// enc_link_arbiter
//   Round-robin arbiter feeding an 8:3 encoded link. One requester is picked
//   in IDLE, its index is offered to the link until accepted (OFFER), and the
//   grant is then held for the transfer (HOLD) until the owner finishes or
//   withdraws its request. Every output is registered.
//
// Optional feature (macro ENC_ARB_TIMEOUT_EN):
//   When defined, an 8-bit counter limits HOLD to TIMEOUT_CYCLES cycles. On
//   expiry the grant is forcibly released and timeout_o pulses for one
//   cycle. When undefined, the counter is absent, timeout_o is tied low and
//   HOLD lasts until a natural release.
//
// Parameters:
//   TIMEOUT_CYCLES  HOLD-state cycle limit before forced release (2..255)
//
// Ports:
//   clk_i         sole clock, rising edge
//   rst_i         synchronous, active-high reset
//   req_i[7:0]    request lines, bit i = requester i
//   link_ready_i  link accepts the offered index this cycle
//   done_i        granted requester finishes its transfer
//   gnt_o[7:0]    one-hot grant, zero when there is no owner
//   out_index_o   binary index of the granted requester
//   out_valid_o   out_index_o is being offered to the link
//   busy_o        state is not IDLE
//   timeout_o     one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module enc_link_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req_i,
  input  logic       link_ready_i,
  input  logic       done_i,
  output logic [7:0] gnt_o,
  output logic [2:0] out_index_o,
  output logic       out_valid_o,
  output logic       busy_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e     state_q;
  logic [7:0] gnt_q;
  logic [2:0] idx_q;
  logic [2:0] last_ptr_q;
  logic       valid_q;
  logic       busy_q;

`ifdef ENC_ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q;
  logic       timeout_q;
`endif

  // Round-robin search: first set request bit scanning upward from
  // last_ptr+1, wrapping 7 -> 0. The 3-bit add gives the wrap for free.
  logic [2:0] pick_idx_d;
  logic       pick_vld_d;

  // NOTE: every variable driven in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    pick_idx_d = '0;
    pick_vld_d = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!pick_vld_d && req_i[last_ptr_q + 3'(k + 1)]) begin
        pick_idx_d = last_ptr_q + 3'(k + 1);
        pick_vld_d = 1'b1;
      end
    end
  end

  // Whether the current owner still holds its request line.
  logic owner_req;
  assign owner_req = req_i[idx_q];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      last_ptr_q <= 3'd7;  // first search after reset starts at bit 0
`ifdef ENC_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
`ifdef ENC_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;  // pulse is only raised on the forced-release edge
`endif
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            state_q <= OFFER;
            gnt_q   <= 8'b1 << pick_idx_d;
            idx_q   <= pick_idx_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        OFFER: begin
          // Withdrawal wins over acceptance; last_ptr is left alone so the
          // same requester may win again.
          if (!owner_req) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (link_ready_i) begin
            state_q <= HOLD;
            valid_q <= 1'b0;
`ifdef ENC_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end

        HOLD: begin
          if (done_i || !owner_req) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            last_ptr_q <= idx_q;
`ifdef ENC_ARB_TIMEOUT_EN
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            last_ptr_q <= idx_q;
            timeout_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
`endif
          end
        end

        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign out_index_o = idx_q;
  assign out_valid_o = valid_q;
  assign busy_o      = busy_q;
`ifdef ENC_ARB_TIMEOUT_EN
  assign timeout_o   = timeout_q;
`else
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_enc_link_arbiter.sv
// -----------------------------------------------------------------------------
// tb_enc_link_arbiter
//   Directed self-checking bench for enc_link_arbiter. Inputs change 1 ns
//   after a rising edge; outputs are sampled at the same point, i.e. they show
//   the result of the edge that just happened. Builds with or without
//   ENC_ARB_TIMEOUT_EN (TIMEOUT_CYCLES is set to 4).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_enc_link_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       link_ready;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] out_index;
  logic       out_valid;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  enc_link_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .link_ready_i (link_ready),
    .done_i       (done),
    .gnt_o        (gnt),
    .out_index_o  (out_index),
    .out_valid_o  (out_valid),
    .busy_o       (busy),
    .timeout_o    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction from IDLE: grant, accept, finish. Checks the grant.
  task automatic grant_cycle(input string tag, input int exp_idx);
    step();
    check({tag, " idx"}, out_index, exp_idx);
    check({tag, " gnt"}, gnt, 1 << exp_idx);
    link_ready = 1'b1;
    step();
    link_ready = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    check({tag, " idle gnt"}, gnt, 0);
  endtask

  initial begin
    rst = 1'b1; req = '0; link_ready = 1'b0; done = 1'b0;

    // Reset state
    step();
    check("rst gnt", gnt, 0);
    check("rst idx", out_index, 0);
    check("rst valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst timeout", timeout, 0);
    rst = 1'b0;

    // IDLE with no requests stays idle
    step();
    check("idle0 busy", busy, 0);
    check("idle0 gnt", gnt, 0);

    // Single request on bit 5, offer held until link_ready
    req = 8'b0010_0000;
    step();
    check("r5 gnt", gnt, 8'h20);
    check("r5 idx", out_index, 5);
    check("r5 valid", out_valid, 1);
    check("r5 busy", busy, 1);
    done = 1'b1;              // ignored in OFFER
    step();
    done = 1'b0;
    check("r5 offer hold valid", out_valid, 1);
    check("r5 offer hold gnt", gnt, 8'h20);
    link_ready = 1'b1;
    step();
    link_ready = 1'b0;
    check("r5 hold valid", out_valid, 0);
    check("r5 hold gnt", gnt, 8'h20);
    check("r5 hold idx", out_index, 5);
    done = 1'b1;
    step();
    done = 1'b0;
    check("r5 release gnt", gnt, 0);
    check("r5 release busy", busy, 0);

    // Round-robin over all requesters from a fresh reset: 0..7 then 0
    rst = 1'b1; req = '0;
    step();
    rst = 1'b0;
    req = 8'hFF;
    for (int g = 0; g < 9; g++) grant_cycle($sformatf("rr%0d", g), g % 8);

    // Owner 3, then search from 4 finds 7, then wrap to 0
    req = 8'b0000_1000;
    grant_cycle("own3", 3);
    req = 8'b1000_1001;
    grant_cycle("after3", 7);
    req = 8'b0000_1001;
    grant_cycle("wrap", 0);

    // Abort in OFFER: withdrawal wins over link_ready, last_ptr unchanged (0)
    req = 8'b0000_0100;
    step();
    check("ab gnt", gnt, 8'h04);
    req = 8'b0000_0000;
    link_ready = 1'b1;
    step();
    link_ready = 1'b0;
    check("ab gnt0", gnt, 0);
    check("ab valid0", out_valid, 0);
    check("ab busy0", busy, 0);
    req = 8'b0000_0101;       // from last_ptr 0 -> 2; from 2 would be 0
    step();
    check("ab regrant idx", out_index, 2);
    link_ready = 1'b1;
    step();
    link_ready = 1'b0;
    req = 8'b1111_0101;       // non-winners ignored in HOLD
    step();
    check("hold nopreempt gnt", gnt, 8'h04);
    req = 8'b0000_0101;

`ifdef ENC_ARB_TIMEOUT_EN
    // HOLD cycles 1,2 done above; cycles 3,4 then forced release
    step();
    check("to hold3 busy", busy, 1);
    step();
    check("to hold4 gnt", gnt, 8'h04);
    check("to hold4 timeout", timeout, 0);
    step();
    check("to release gnt", gnt, 0);
    check("to pulse", timeout, 1);
    step();
    check("to pulse end", timeout, 0);
    check("to next idx", out_index, 0);
`else
    for (int i = 0; i < 110; i++) step();
    check("notimeout gnt", gnt, 8'h04);
    check("notimeout busy", busy, 1);
    check("notimeout tpin", timeout, 0);
    done = 1'b1;
    step();
    done = 1'b0;
    check("notimeout rel", gnt, 0);
    step();
    check("notimeout next idx", out_index, 0);
`endif

    // Reset during HOLD
    link_ready = 1'b1;
    step();
    link_ready = 1'b0;
    check("pre-rst busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("hrst gnt", gnt, 0);
    check("hrst busy", busy, 0);
    check("hrst timeout", timeout, 0);
    req = 8'b1000_0001;
    step();
    check("hrst first idx", out_index, 0);
    check("hrst first gnt", gnt, 8'h01);
    link_ready = 1'b1;
    step();
    link_ready = 1'b0;
    req = 8'b1000_0000;       // owner withdraws in HOLD -> release
    step();
    check("wd release gnt", gnt, 0);
    req = 8'b1000_0001;
    step();
    check("wd next idx", out_index, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
